// File: rtl/conv_bus_pkg.sv
// Shared types for the conv bus memory responder: FSM states, burst context and
// the per-beat address step helper.
package conv_bus_pkg;

  localparam int unsigned CONV_ADDR_W = 28;
  localparam int unsigned CONV_ID_W   = 4;
  localparam int unsigned CONV_LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2,
    WR_DATA = 2'd3
  } resp_state_t;

  typedef struct packed {
    logic [CONV_ADDR_W-1:0] addr;
    logic [CONV_LEN_W-1:0]  cnt;
    logic [CONV_ID_W-1:0]   id;
    logic                   ap;
  } burst_ctx_t;

  // Incrementing bursts wrap modulo 2^ADDR_W; fixed bursts hold the address.
  function automatic logic [CONV_ADDR_W-1:0] step_addr(input logic [CONV_ADDR_W-1:0] addr,
                                                       input logic                   ap);
    return ap ? addr + 1'b1 : addr;
  endfunction

endpackage

// File: rtl/conv_resp_sram.sv
// Single-port byte-enabled SRAM, WIDTH x DEPTH, synchronous read with one cycle
// of latency. A write cycle leaves the read register untouched.
module conv_resp_sram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [WIDTH/8-1:0]       be_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto a RAM macro; contents survive rst.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < WIDTH / 8; b++) begin
          if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_mem_responder.sv
// Memory-side responder for the conv bus: serves one read or write burst at a
// time from an internal SRAM. Optional range checking via CONV_RESP_RANGE_CHK_EN.
module conv_mem_responder
  import conv_bus_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = CONV_ADDR_W,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ID_W   = CONV_ID_W,
  parameter int unsigned LEN_W  = CONV_LEN_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arvalid,
  output logic               arready,
  input  logic [ADDR_W-1:0]  araddr,
  input  logic [LEN_W-1:0]   arlen,
  input  logic [ID_W-1:0]    aruser_id,
  input  logic               aruser_ap,
  output logic               rvalid,
  output logic               rlast,
  output logic [ID_W-1:0]    rid,
  output logic [WIDTH-1:0]   rdata,
  input  logic               awvalid,
  output logic               awready,
  input  logic [ADDR_W-1:0]  awaddr,
  input  logic [LEN_W-1:0]   awlen,
  input  logic [ID_W-1:0]    awuser_id,
  input  logic               awuser_ap,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wstrb,
  output logic               wready,
  output logic [ID_W-1:0]    wuser_id,
  output logic               wuser_last,
  output logic               err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  // The burst context uses the package field widths.
  if (ADDR_W != CONV_ADDR_W || ID_W != CONV_ID_W || LEN_W != CONV_LEN_W) begin : g_width_guard
    $error("conv_mem_responder: ADDR_W/ID_W/LEN_W must match conv_bus_pkg");
  end

  resp_state_t      state_q, state_d;
  burst_ctx_t       ctx_q, ctx_d;
  logic             rr_q, rr_d;
  logic             idle, conflict, ar_hs, aw_hs;
  logic             rd_issue, rd_beat, wr_beat, last_beat, sram_we;
  logic [WIDTH-1:0] sram_rdata;

  assign idle      = (state_q == IDLE) && !rst;
  assign conflict  = arvalid && awvalid;
  // rr_q=1 means the write side lost the last conflict and now has priority.
  assign arready   = idle && !(conflict && rr_q);
  assign awready   = idle && !(conflict && !rr_q);
  assign ar_hs     = arvalid && arready;
  assign aw_hs     = awvalid && awready;

  assign rd_issue  = (state_q == RD_ADDR) || (state_q == RD_DATA);
  assign rd_beat   = (state_q == RD_DATA);
  assign wr_beat   = (state_q == WR_DATA);
  assign last_beat = (ctx_q.cnt == '0);

  assign rvalid     = rd_beat;
  assign rlast      = rd_beat && last_beat;
  assign rid        = rd_beat ? ctx_q.id : '0;
  assign wready     = wr_beat;
  assign wuser_last = wr_beat && last_beat;
  assign wuser_id   = wr_beat ? ctx_q.id : '0;

  // NOTE: every next-state signal gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    ctx_d   = ctx_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (conflict) rr_d = ~rr_q;
        if (ar_hs) begin
          state_d = RD_ADDR;
          ctx_d   = '{addr: araddr, cnt: arlen, id: aruser_id, ap: aruser_ap};
        end else if (aw_hs) begin
          state_d = WR_DATA;
          ctx_d   = '{addr: awaddr, cnt: awlen, id: awuser_id, ap: awuser_ap};
        end
      end
      RD_ADDR: begin
        state_d    = RD_DATA;
        ctx_d.addr = step_addr(ctx_q.addr, ctx_q.ap);
      end
      RD_DATA, WR_DATA: begin
        // In RD_DATA the address already runs one beat ahead of the data.
        ctx_d.addr = step_addr(ctx_q.addr, ctx_q.ap);
        ctx_d.cnt  = ctx_q.cnt - 1'b1;
        if (last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctx_q   <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ctx_q   <= ctx_d;
      rr_q    <= rr_d;
    end
  end

`ifdef CONV_RESP_RANGE_CHK_EN
  logic oor, rd_oor_q, err_q;

  assign oor = {1'b0, ctx_q.addr} >= (CONV_ADDR_W + 1)'(DEPTH);

  // rd_oor_q travels alongside the SRAM read so it lines up with the data beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_oor_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (rd_issue) rd_oor_q <= oor;
      if ((wr_beat && oor) || (rd_beat && rd_oor_q)) err_q <= 1'b1;
    end
  end

  assign sram_we = wr_beat && !oor;
  assign rdata   = (rd_beat && !rd_oor_q) ? sram_rdata : '0;
  assign err     = err_q;
`else
  assign sram_we = wr_beat;
  assign rdata   = rd_beat ? sram_rdata : '0;
  assign err     = 1'b0;
`endif

  conv_resp_sram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_sram (
    .clk     (clk),
    .en_i    (rd_issue || wr_beat),
    .we_i    (sram_we),
    .be_i    (wstrb),
    .addr_i  (ctx_q.addr[IDX_W-1:0]),
    .wdata_i (wdata),
    .rdata_o (sram_rdata)
  );

endmodule

// File: tb/tb_conv_mem_responder.sv
// Self-checking bench for conv_mem_responder: a burst-level model predicts every
// output cycle by cycle, and directed tests pin hand-computed values.
module tb_conv_mem_responder;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 28;
  localparam int DEPTH  = 4096;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 4;
`ifdef CONV_RESP_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              arvalid = 1'b0, arready;
  logic [ADDR_W-1:0] araddr = '0;
  logic [LEN_W-1:0]  arlen = '0;
  logic [ID_W-1:0]   aruser_id = '0;
  logic              aruser_ap = 1'b0;
  logic              rvalid, rlast;
  logic [ID_W-1:0]   rid;
  logic [WIDTH-1:0]  rdata;
  logic              awvalid = 1'b0, awready;
  logic [ADDR_W-1:0] awaddr = '0;
  logic [LEN_W-1:0]  awlen = '0;
  logic [ID_W-1:0]   awuser_id = '0;
  logic              awuser_ap = 1'b0;
  logic [WIDTH-1:0]  wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              wready, wuser_last, err;
  logic [ID_W-1:0]   wuser_id;

  always #5 clk = ~clk;

  conv_mem_responder #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ID_W(ID_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .aruser_id(aruser_id), .aruser_ap(aruser_ap),
    .rvalid(rvalid), .rlast(rlast), .rid(rid), .rdata(rdata),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awuser_id(awuser_id), .awuser_ap(awuser_ap),
    .wdata(wdata), .wstrb(wstrb), .wready(wready), .wuser_id(wuser_id),
    .wuser_last(wuser_last), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int cyc; logic [31:0] data; logic [3:0] id; bit last; bit oor; } rd_exp_t;
  typedef struct { int cyc; logic [27:0] addr; logic [3:0] id; bit last; } wr_exp_t;

  rd_exp_t     rd_q[$];
  wr_exp_t     wr_q[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] got_rd[$];
  int          cyc = 0;
  int          busy_until = 0;
  bit          rr_m = 1'b0;
  bit          err_m = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [27:0] beat_addr(input logic [27:0] base, input bit ap, input int b);
    return ap ? base + 28'(b) : base;
  endfunction

  function automatic bit out_of_range(input logic [27:0] a);
    return RANGE_CHK && (a >= 28'(DEPTH));
  endfunction

  initial begin : compare
    bit armed;
    armed = 1'b0;
    forever begin
      @(negedge clk);
      if (!armed) begin
        if (rst) armed = 1'b1;
      end else begin
        bit idle_m, exp_ar, exp_aw, exp_rv, exp_wr, err_set;
        err_set = 1'b0;
        idle_m  = !rst && (cyc > busy_until);
        exp_ar  = idle_m && !(arvalid && awvalid && rr_m);
        exp_aw  = idle_m && !(arvalid && awvalid && !rr_m);
        check("arready", arready, exp_ar);
        check("awready", awready, exp_aw);

        exp_rv = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
        check("rvalid", rvalid, exp_rv);
        if (exp_rv) begin
          if (rvalid) begin
            check("rdata", rdata, rd_q[0].data);
            check("rid", rid, rd_q[0].id);
            check("rlast", rlast, rd_q[0].last);
            got_rd.push_back(rdata);
          end
          if (rd_q[0].oor) err_set = 1'b1;
          void'(rd_q.pop_front());
        end else begin
          check("rlast_idle", rlast, 1'b0);
        end

        exp_wr = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
        check("wready", wready, exp_wr);
        if (exp_wr) begin
          if (wready) begin
            check("wuser_id", wuser_id, wr_q[0].id);
            check("wuser_last", wuser_last, wr_q[0].last);
          end
          if (out_of_range(wr_q[0].addr)) begin
            err_set = 1'b1;
          end else begin
            for (int b = 0; b < 4; b++)
              if (wstrb[b]) mem_m[int'(wr_q[0].addr) % DEPTH][b*8 +: 8] = wdata[b*8 +: 8];
          end
          void'(wr_q.pop_front());
        end else begin
          check("wuser_last_idle", wuser_last, 1'b0);
        end

        check("err", err, err_m);
        if (err_set) err_m = 1'b1;

        if (rst) begin
          rd_q.delete();
          wr_q.delete();
          busy_until = cyc;
          rr_m  = 1'b0;
          err_m = 1'b0;
        end else begin
          if (idle_m && arvalid && awvalid) rr_m = !rr_m;
          if (exp_ar && arvalid) begin
            for (int b = 0; b <= int'(arlen); b++) begin
              rd_exp_t     e;
              logic [27:0] a;
              a      = beat_addr(araddr, aruser_ap, b);
              e.cyc  = cyc + 2 + b;
              e.id   = aruser_id;
              e.last = (b == int'(arlen));
              e.oor  = out_of_range(a);
              e.data = e.oor ? 32'h0 : mem_m[int'(a) % DEPTH];
              rd_q.push_back(e);
            end
            busy_until = cyc + 2 + int'(arlen);
          end else if (exp_aw && awvalid) begin
            for (int b = 0; b <= int'(awlen); b++) begin
              wr_exp_t w;
              w.cyc  = cyc + 1 + b;
              w.addr = beat_addr(awaddr, awuser_ap, b);
              w.id   = awuser_id;
              w.last = (b == int'(awlen));
              wr_q.push_back(w);
            end
            busy_until = cyc + 1 + int'(awlen);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] ex [16];

  // Called just after a rising edge; returns just after the edge following the handshake.
  task automatic request(input bit rd, input bit wr, output bit took_rd, output bit took_wr);
    bit done;
    done = 1'b0; took_rd = 1'b0; took_wr = 1'b0;
    arvalid = rd; awvalid = wr;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      took_rd = rd && arready;
      took_wr = wr && awready && !took_rd;
      done    = took_rd || took_wr;
      @(posedge clk); #1;
    end
    arvalid = 1'b0; awvalid = 1'b0;
    check("handshake_in_time", done, 1'b1);
  endtask

  task automatic drive_wdata(input int len);
    for (int b = 0; b <= len; b++) begin
      wdata = wd[b]; wstrb = ws[b];
      @(posedge clk); #1;
    end
    wdata = '0; wstrb = '0;
  endtask

  task automatic wr_burst(input logic [27:0] a, input int len, input logic [3:0] id, input bit ap);
    bit tr, tw;
    awaddr = a; awlen = 4'(len); awuser_id = id; awuser_ap = ap;
    request(1'b0, 1'b1, tr, tw);
    drive_wdata(len);
  endtask

  task automatic rd_burst(input logic [27:0] a, input int len, input logic [3:0] id, input bit ap);
    bit tr, tw;
    araddr = a; arlen = 4'(len); aruser_id = id; aruser_ap = ap;
    got_rd.delete();
    request(1'b1, 1'b0, tr, tw);
    repeat (len + 2) begin @(posedge clk); #1; end
  endtask

  task automatic check_got(input string name, input int n);
    check({name, "_beats"}, got_rd.size(), n);
    for (int i = 0; i < n && i < got_rd.size(); i++) check(name, got_rd[i], ex[i]);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin : stim
    bit tr, tw;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_arready", arready, 1'b0);
    check("rst_awready", awready, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_rid", rid, 4'h0);
    check("rst_wuser_id", wuser_id, 4'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_arready", arready, 1'b1);
    @(posedge clk); #1;

    // 1: incrementing write then read-after-write of the same range
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; ex[i] = 32'hA0 + 32'(i); end
    wr_burst(28'h10, 3, 4'd5, 1'b1);
    rd_burst(28'h10, 3, 4'd2, 1'b1);
    check_got("t1_rdata", 4);

    // 2: byte strobes, including an all-zero strobe
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    wr_burst(28'h20, 0, 4'd1, 1'b1);
    wd[0] = 32'h1234_5678; ws[0] = 4'b0101;
    wr_burst(28'h20, 0, 4'd1, 1'b1);
    ex[0] = 32'hFF34_FF78;
    rd_burst(28'h20, 0, 4'd9, 1'b1);
    check_got("t2_strobe", 1);
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'h0;
    wr_burst(28'h20, 0, 4'd1, 1'b1);
    rd_burst(28'h20, 0, 4'd9, 1'b1);
    check_got("t2_zero_strobe", 1);

    // 3: simultaneous requests alternate read, write, read
    araddr = 28'h10; arlen = 4'd1; aruser_id = 4'd3; aruser_ap = 1'b1;
    awaddr = 28'h50; awlen = 4'd0; awuser_id = 4'd4; awuser_ap = 1'b1;
    wd[0] = 32'h55; ws[0] = 4'hF;
    request(1'b1, 1'b1, tr, tw);
    check("t3_grant1_read", tr, 1'b1);
    check("t3_grant1_write", tw, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    request(1'b1, 1'b1, tr, tw);
    check("t3_grant2_read", tr, 1'b0);
    check("t3_grant2_write", tw, 1'b1);
    drive_wdata(0);
    got_rd.delete();
    request(1'b1, 1'b1, tr, tw);
    check("t3_grant3_read", tr, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    ex[0] = 32'hA0; ex[1] = 32'hA1;
    check_got("t3_rdata", 2);

    // 4: incrementing burst across the top of the SRAM
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0 + 32'(i); ws[i] = 4'hF; end
    wr_burst(28'(DEPTH - 2), 3, 4'd6, 1'b1);
    @(negedge clk);
    check("t4_err_after_write", err, RANGE_CHK);
    @(posedge clk); #1;
    ex[0] = 32'hC0; ex[1] = 32'hC1;
    ex[2] = RANGE_CHK ? 32'h0 : 32'hC2;
    ex[3] = RANGE_CHK ? 32'h0 : 32'hC3;
    rd_burst(28'(DEPTH - 2), 3, 4'd6, 1'b1);
    check_got("t4_wrap", 4);

    // 5: fixed-address write keeps the last beat; reset aborts a read burst
    wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3;
    ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
    wr_burst(28'h40, 2, 4'd8, 1'b0);
    ex[0] = 32'd3; ex[1] = 32'd3;
    rd_burst(28'h40, 1, 4'd8, 1'b0);
    check_got("t5_fixed", 2);

    araddr = 28'h10; arlen = 4'd3; aruser_id = 4'd7; aruser_ap = 1'b1;
    got_rd.delete();
    request(1'b1, 1'b0, tr, tw);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_rvalid_after_rst", rvalid, 1'b0);
    check("t5_arready_after_rst", arready, 1'b1);
    check("t5_err_after_rst", err, 1'b0);
    ex[0] = 32'hA0; ex[1] = 32'hA1;
    check_got("t5_aborted", 2);
    @(posedge clk); #1;
    ex[0] = 32'd3;
    rd_burst(28'h40, 0, 4'd1, 1'b1);
    check_got("t5_kept", 1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
